inst_image_loader: RTL
======================

Name: inst_image_loader

Overview:
- Sequential loader that sits directly downstream of a program-image block (a constant `mem_inst` word array, e.g. the fib test images).
- Walks the image from index 0 upward and writes each word into the core's instruction RAM through a ready/valid write port.
- Stops after writing the terminator word `0xFFFFFFFF`.
- Holds the CPU core in reset until loading completes, so swapping a test program means swapping the image block only.

Parameters:
- IMG_DEPTH, 200, number of words on the image input (matches instruction-image array size).
- ADDR_W, 8, width of RAM word address; must satisfy 2**ADDR_W >= BASE_ADDR+IMG_DEPTH.
- BASE_ADDR, 0, RAM word address that receives image index 0.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin/restart a load (level sampled each cycle)
- image  input  32 x IMG_DEPTH (unpacked [IMG_DEPTH-1:0])  program image; index 0 = first instruction
- wr_en  output  1  write request valid
- wr_addr  output  ADDR_W  RAM word address
- wr_data  output  32  RAM write data
- wr_ready  input  1  RAM accepts write this cycle
- cpu_hold  output  1  high = keep CPU core in reset
- done  output  1  load finished with terminator found
- error  output  1  image exhausted without terminator
- word_count  output  ADDR_W+1  words written in current/last load (terminator included)

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE; wr_en=0, wr_addr=BASE_ADDR, wr_data=0.
  - cpu_hold=1, done=0, error=0, word_count=0.
  - Applies from any state, including mid-LOAD; an outstanding write is dropped with no further handshake.
- States: IDLE, LOAD, DONE, ERR.
- IDLE:
  - cpu_hold=1.
  - start=1 → LOAD next cycle: idx=0, wr_en=1, wr_addr=BASE_ADDR, wr_data=image[0], word_count=0.
- LOAD, write handshake:
  - A transfer occurs on a cycle where wr_en && wr_ready.
  - wr_addr and wr_data stay stable while wr_en=1 && wr_ready=0; wr_en never drops without a transfer.
- LOAD, on each transfer:
  - word_count increments.
  - If wr_data==0xFFFFFFFF → DONE next cycle; wr_en=0.
  - Else if idx==IMG_DEPTH-1 → ERR next cycle; wr_en=0.
  - Else idx+1, next cycle wr_addr+1, wr_data=image[idx+1], wr_en stays 1.
- Throughput: with wr_ready tied high, one word per cycle. N words occupy N consecutive cycles; done rises the cycle after the last transfer.
- The terminator word itself is written (the core uses it as a halt marker).
- start is ignored while in LOAD.
- DONE: done=1, cpu_hold=0.
- ERR: error=1, cpu_hold=1.
- From DONE or ERR, start=1 → LOAD as from IDLE: done/error clear and cpu_hold=1, all in the same cycle LOAD is entered.
- word_count holds its final value in DONE/ERR until the next load or reset.
- image is sampled combinationally via idx; it must be stable during LOAD.
- Address arithmetic is unsigned, mod 2**ADDR_W. With a legal parameter set no wrap can occur.

Optional Feature:
- Macro INST_IMAGE_LOADER_CHECKSUM_EN.
- With it defined:
  - Extra output `checksum` (32 bits), reset to 0 and cleared on entry to LOAD.
  - On each transfer: checksum <= {checksum[30:0],checksum[31]} ^ wr_data. The terminator is included.
  - Value is valid and held in DONE/ERR.
- Without it: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package `cpu_pkg`:
  - word_t (logic [31:0]).
  - TERM_WORD = 32'hFFFF_FFFF.
  - loader_state_t enum {IDLE, LOAD, DONE, ERR}.
- Single module; no sub-module. The state register, idx counter and optional checksum are small enough to keep inline.

Test Plan:
- Fib image (44 words, index 0 = 0x20010003, index 43 = 0xFFFFFFFF), wr_ready=1, start pulse:
  - 44 consecutive transfers to addr 0..43; last wr_data=0xFFFFFFFF.
  - done=1 and cpu_hold=0 exactly one cycle after the 44th transfer; word_count=44.
- Same image, wr_ready low on every other cycle:
  - addr/data held stable across stall cycles; still exactly 44 transfers, no duplicates or skips; done after the 44th.
- Image with no 0xFFFFFFFF word, IMG_DEPTH=200:
  - 200 transfers to addr 0..199.
  - error=1, done=0, cpu_hold=1, word_count=200.
- rst asserted after transfer 10 while wr_en=1:
  - Next cycle: wr_en=0, cpu_hold=1, word_count=0, state IDLE.
  - A fresh start restarts at addr BASE_ADDR.
- start held high throughout LOAD, then pulsed again in DONE:
  - No effect during LOAD.
  - In DONE: a second full 44-word load; done drops and cpu_hold rises in the cycle LOAD is entered.
- With INST_IMAGE_LOADER_CHECKSUM_EN and a 2-word image {0x00000001, 0xFFFFFFFF}:
  - checksum = rotl(0x00000001,1) ^ 0xFFFFFFFF = 0xFFFFFFFD in DONE.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared word type, terminator constant and loader state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t TERM_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_image_loader.sv
// ============================================================================
// Module : inst_image_loader
// Brief  : Copies a constant program image into instruction RAM word by word,
//          holding the CPU in reset until the terminator word has been written.
//          Optional rolling checksum: define INST_IMAGE_LOADER_CHECKSUM_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_image_loader
  import cpu_pkg::*;
#(
  parameter int IMG_DEPTH = 200,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       image [IMG_DEPTH-1:0],
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
`ifdef INST_IMAGE_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int c_IDX_W = (IMG_DEPTH > 1) ? $clog2(IMG_DEPTH) : 1;

  loader_state_t      r_state;
  loader_state_t      w_state_nxt;
  logic [c_IDX_W-1:0] r_idx;
  word_t              w_cur_word;
  logic               w_xfer;
  logic               w_is_term;
  logic               w_last_idx;
  logic               w_start_load;

  assign w_cur_word   = image[r_idx];
  assign w_xfer       = (r_state == LOAD) && wr_ready;
  assign w_is_term    = (w_cur_word == TERM_WORD);
  assign w_last_idx   = (r_idx == c_IDX_W'(IMG_DEPTH - 1));
  assign w_start_load = start && (r_state != LOAD);

  // Address follows idx directly, so it is stable whenever idx is held by a stall.
  assign wr_en    = (r_state == LOAD);
  assign wr_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx);
  assign wr_data  = wr_en ? w_cur_word : '0;
  assign done     = (r_state == DONE);
  assign error    = (r_state == ERR);
  assign cpu_hold = (r_state != DONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE, ERR: begin
        if (start) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (w_xfer) begin
          if (w_is_term)       w_state_nxt = DONE;
          else if (w_last_idx) w_state_nxt = ERR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      word_count <= '0;
    end else if (w_start_load) begin
      r_idx      <= '0;
      word_count <= '0;
    end else if (w_xfer) begin
      word_count <= word_count + 1'b1;
      if (!w_is_term && !w_last_idx) r_idx <= r_idx + 1'b1;
    end
  end

`ifdef INST_IMAGE_LOADER_CHECKSUM_EN
  // Rotate-left-by-one then XOR each written word, terminator included.
  always_ff @(posedge clk) begin
    if (rst || w_start_load) checksum <= '0;
    else if (w_xfer)         checksum <= {checksum[30:0], checksum[31]} ^ wr_data;
  end
`endif

endmodule

`default_nettype wire
